// File: rtl/midi_writer.sv
// MIDI serial transmitter: frames 1-3 byte MIDI messages as 8N1 at BAUD_RATE.
// Optional running status is enabled by defining MIDI_RUNNING_STATUS_EN.
module midi_writer #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 31_250
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] status_in,
    input  logic [7:0] data_byte1_in,
    input  logic [7:0] data_byte2_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_wire_out,
    output logic       done_out,
    output logic       error_out,
    output logic [2:0] fsm_state
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [1:0]       byte_idx, byte_next;
    logic [1:0]       last_idx, last_next;
    logic [7:0]       msg0, msg1, msg2;
    logic [7:0]       msg0_next, msg1_next, msg2_next;
    logic             err, err_next;

    logic [1:0]       msg_len;
    logic [1:0]       load_last;
    logic [7:0]       load0, load1, load2;
    logic             skip_status;
    logic [7:0]       cur_byte;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] rs_byte;
    logic       rs_valid;
`endif

    // Message length from the status byte; zero marks a rejected status.
    always_comb begin
        msg_len = 2'd0;
        case (status_in[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: msg_len = 2'd3;
            4'hC, 4'hD:                   msg_len = 2'd2;
            4'hF:                         msg_len = status_in[3] ? 2'd1 : 2'd0;
            default:                      msg_len = 2'd0;
        endcase
    end

    always_comb begin
        load0       = status_in;
        load1       = data_byte1_in & 8'h7F;
        load2       = data_byte2_in & 8'h7F;
        load_last   = msg_len - 2'd1;
        skip_status = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        skip_status = rs_valid && (status_in == rs_byte) && (msg_len >= 2'd2);
`endif
        if (skip_status) begin
            load0     = load1;
            load1     = load2;
            load_last = msg_len - 2'd2;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        byte_next  = byte_idx;
        last_next  = last_idx;
        msg0_next  = msg0;
        msg1_next  = msg1;
        msg2_next  = msg2;
        err_next   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next  = '0;
                bit_next  = 3'd0;
                byte_next = 2'd0;
                if (valid_in) begin
                    if (msg_len == 2'd0) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = S_START;
                        msg0_next  = load0;
                        msg1_next  = load1;
                        msg2_next  = load2;
                        last_next  = load_last;
                    end
                end
            end
            S_START: begin
                if (cnt == LAST_CNT) begin
                    cnt_next   = '0;
                    state_next = S_DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_next   = 3'd0;
                        state_next = S_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_next = '0;
                    if (byte_idx == last_idx) begin
                        state_next = S_DONE;
                    end else begin
                        byte_next  = byte_idx + 2'd1;
                        state_next = S_START;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            last_idx <= 2'd0;
            msg0     <= 8'd0;
            msg1     <= 8'd0;
            msg2     <= 8'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_next;
            byte_idx <= byte_next;
            last_idx <= last_next;
            msg0     <= msg0_next;
            msg1     <= msg1_next;
            msg2     <= msg2_next;
            err      <= err_next;
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    // Channel messages set the stored status, real-time leaves it, rejects clear it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rs_byte  <= 8'd0;
            rs_valid <= 1'b0;
        end else if (state == S_IDLE && valid_in) begin
            if (msg_len == 2'd0) begin
                rs_valid <= 1'b0;
            end else if (msg_len >= 2'd2) begin
                rs_byte  <= status_in;
                rs_valid <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = msg0;
            2'd1:    cur_byte = msg1;
            default: cur_byte = msg2;
        endcase
    end

    always_comb begin
        case (state)
            S_START: tx_wire_out = 1'b0;
            S_DATA:  tx_wire_out = cur_byte[bit_idx];
            default: tx_wire_out = 1'b1;
        endcase
    end

    assign ready_out = (state == S_IDLE);
    assign done_out  = (state == S_DONE);
    assign error_out = err;
    assign fsm_state = state;

endmodule

// File: doc/midi_writer.md
MIDI_WRITER -- requirements
Module: midi_writer

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 31_250, MIDI line rate in bits/s; BAUD_DIV = CLK_FREQ/BAUD_RATE (3200 at defaults).
REQ-003 clk_in  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 status_in  input  8  full MIDI status byte (type nibble + channel nibble).
REQ-006 data_byte1_in  input  8  first data byte; bit 7 ignored.
REQ-007 data_byte2_in  input  8  second data byte; bit 7 ignored.
REQ-008 valid_in  input  1  message request; accepted on a cycle where valid_in & ready_out.
REQ-009 ready_out  output  1  high only when idle and able to accept a message.
REQ-010 tx_wire_out  output  1  serial MIDI line, idle high.
REQ-011 done_out  output  1  one-cycle pulse after the final stop bit of a message.
REQ-012 error_out  output  1  one-cycle pulse when an accepted message is rejected.

Function
REQ-013 Message length is decided from status_in[7:4] at acceptance: 0x8,0x9,0xA,0xB,0xE -> 3 bytes; 0xC,0xD -> 2 bytes; status 0xF8-0xFF -> 1 byte (real-time).
REQ-014 Rejected messages: status_in[7]=0 or status 0xF0-0xF7; error_out pulses the cycle after acceptance; line stays high; ready_out stays high.
REQ-015 Inputs are registered at acceptance; later changes to inputs do not affect the frame in progress.
REQ-016 Each byte is framed as start bit (0), 8 data bits LSB first, stop bit (1); each bit is held exactly BAUD_DIV cycles.
REQ-017 The start bit of the first byte begins the cycle after acceptance; bytes of one message are sent back-to-back with no idle gap.
REQ-018 State machine: IDLE -> START -> DATA (8 bits) -> STOP -> START for the next byte, or DONE after the last byte -> IDLE.
REQ-019 DONE lasts one cycle, asserts done_out, and drives the line high; ready_out rises the following cycle.
REQ-020 ready_out is low from the cycle after acceptance until IDLE is re-entered; valid_in while not ready is ignored and not queued.
REQ-021 The bit counter counts 0..BAUD_DIV-1 and the bit index counts 0..7; both wrap to 0 at each boundary.
REQ-022 Message duration is bytes x 10 x BAUD_DIV cycles, plus one DONE cycle.

Reset
REQ-023 When rst_in is high: state=IDLE, tx_wire_out=1, ready_out=1 (registered: high from the first cycle after reset), done_out=0, error_out=0, all counters 0, running-status register cleared.
REQ-024 Reset asserted mid-frame aborts the message immediately; the line returns high the next cycle, done_out does not pulse, and the message is not resumed.

Configuration
REQ-025 Macro MIDI_RUNNING_STATUS_EN: when defined, a channel message whose status byte equals the last transmitted channel status omits the status byte (sends 2 or 1 bytes). Real-time messages neither use nor clear the stored status. Rejected messages clear it.
REQ-026 Without MIDI_RUNNING_STATUS_EN, the status byte is always transmitted and no status register is implemented.

Verification
REQ-027 Note-on 0x90,0x3C,0x64 after reset -> 3 frames, line low at cycle 1 after accept, bits 0x90 LSB first, done_out at cycle 96001, ready_out high at cycle 96002.
REQ-028 Program change 0xC5,0x07,0xFF -> 2 frames 0xC5,0x07, done_out at cycle 64001; data_byte2 never appears on the line.
REQ-029 Status 0x3C and status 0xF0 -> error_out pulse the next cycle each, tx_wire_out constantly 1, ready_out never low.
REQ-030 With MIDI_RUNNING_STATUS_EN: 0x90,0x3C,0x64 then 0x90,0x40,0x00 -> second message sends 0x40,0x00 only (64000 cycles); then 0xF8 (1 frame), then 0x90,0x43,0x10 -> 2 frames.
REQ-031 rst_in pulsed at cycle 40000 of a 3-byte message -> line high next cycle, no done_out, ready_out high; next message 0x80,0x3C,0x00 transmits a full 3 frames.
REQ-032 valid_in held high with changing data during transmission -> only the first message is sent and its bytes are unchanged.
